// File: rtl/sdram_arbit.sv
// sdram_arbit: SDRAM command arbiter for init/refresh/write/read requesters; define ARBIT_RR_EN for write/read round-robin
module sdram_arbit (
    input  logic        sysclk_100M,
    input  logic        rst,
    input  logic        init_end,
    input  logic [3:0]  init_cmd,
    input  logic [12:0] init_addr,
    input  logic        refresh_req,
    input  logic        refresh_end,
    input  logic [3:0]  refresh_cmd,
    output logic        refresh_ack,
    input  logic        write_req,
    input  logic        write_end,
    input  logic [3:0]  write_cmd,
    input  logic [1:0]  write_ba,
    input  logic [12:0] write_addr,
    output logic        write_ack,
    input  logic        read_req,
    input  logic        read_end,
    input  logic [3:0]  read_cmd,
    input  logic [1:0]  read_ba,
    input  logic [12:0] read_addr,
    output logic        read_ack,
    output logic [3:0]  sdram_cmd,
    output logic [1:0]  sdram_ba,
    output logic [12:0] sdram_addr,
    output logic [2:0]  arbit_state
);
    localparam logic [3:0] NOP = 4'b0111;

    typedef enum logic [2:0] {
        INIT    = 3'd0,
        ARBIT   = 3'd1,
        REFRESH = 3'd2,
        WRITE   = 3'd3,
        READ    = 3'd4
    } state_t;

    state_t state_q, state_d;
    logic   pick_write;

`ifdef ARBIT_RR_EN
    logic last_grant_q, last_grant_d;
    assign pick_write   = write_req && !(read_req && last_grant_q);
    assign last_grant_d = (state_q == ARBIT && !refresh_req && (write_req || read_req)) ? pick_write : last_grant_q;
    // remember whether the last write/read grant went to write (1) or read (0)
    always_ff @(posedge sysclk_100M or posedge rst) begin
        if (rst) last_grant_q <= 1'b0;
        else     last_grant_q <= last_grant_d;
    end
`else
    assign pick_write = write_req;
`endif

    // state register, reset aborts straight back to INIT
    always_ff @(posedge sysclk_100M or posedge rst) begin
        if (rst) state_q <= INIT;
        else     state_q <= state_d;
    end

    // next state: grants only from ARBIT, so a NOP cycle always separates two grants
    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:    state_d = init_end ? ARBIT : INIT;
            ARBIT:   state_d = refresh_req ? REFRESH : pick_write ? WRITE : read_req ? READ : ARBIT;
            REFRESH: state_d = refresh_end ? ARBIT : REFRESH;
            WRITE:   state_d = write_end ? ARBIT : WRITE;
            READ:    state_d = read_end ? ARBIT : READ;
            default: state_d = INIT;
        endcase
    end

    // command/address mux selected by the current owner
    always_comb begin
        sdram_cmd  = NOP;
        sdram_ba   = 2'd0;
        sdram_addr = 13'd0;
        case (state_q)
            INIT: begin
                sdram_cmd  = init_cmd;
                sdram_addr = init_addr;
            end
            REFRESH: sdram_cmd = refresh_cmd;
            WRITE: begin
                sdram_cmd  = write_cmd;
                sdram_ba   = write_ba;
                sdram_addr = write_addr;
            end
            READ: begin
                sdram_cmd  = read_cmd;
                sdram_ba   = read_ba;
                sdram_addr = read_addr;
            end
            default: sdram_cmd = NOP;
        endcase
    end

    assign refresh_ack = (state_q == REFRESH);
    assign write_ack   = (state_q == WRITE);
    assign read_ack    = (state_q == READ);
    assign arbit_state = state_q;
endmodule

// File: tb/tb_sdram_arbit.sv
// tb_sdram_arbit: directed scenarios plus randomized traffic checked against a behavioural arbiter model
module tb_sdram_arbit;
    localparam int S_INIT = 0, S_ARB = 1, S_REF = 2, S_WR = 3, S_RD = 4;
`ifdef ARBIT_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        sysclk_100M, rst;
    logic        init_end, refresh_req, refresh_end, write_req, write_end, read_req, read_end;
    logic [3:0]  init_cmd, refresh_cmd, write_cmd, read_cmd;
    logic [12:0] init_addr, write_addr, read_addr;
    logic [1:0]  write_ba, read_ba;
    logic        refresh_ack, write_ack, read_ack;
    logic [3:0]  sdram_cmd;
    logic [1:0]  sdram_ba;
    logic [12:0] sdram_addr;
    logic [2:0]  arbit_state;

    int n_chk = 0, n_fail = 0;
    int m_st = S_INIT;
    bit m_last_wr = 1'b0;

    sdram_arbit dut (
        .sysclk_100M(sysclk_100M), .rst(rst),
        .init_end(init_end), .init_cmd(init_cmd), .init_addr(init_addr),
        .refresh_req(refresh_req), .refresh_end(refresh_end), .refresh_cmd(refresh_cmd), .refresh_ack(refresh_ack),
        .write_req(write_req), .write_end(write_end), .write_cmd(write_cmd), .write_ba(write_ba),
        .write_addr(write_addr), .write_ack(write_ack),
        .read_req(read_req), .read_end(read_end), .read_cmd(read_cmd), .read_ba(read_ba),
        .read_addr(read_addr), .read_ack(read_ack),
        .sdram_cmd(sdram_cmd), .sdram_ba(sdram_ba), .sdram_addr(sdram_addr), .arbit_state(arbit_state)
    );

    initial sysclk_100M = 1'b0;
    always #5 sysclk_100M = ~sysclk_100M;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // owner-based model: who holds the bus, and who wins an arbitration round
    task automatic model_step();
        bit take_w;
        if (rst) begin
            m_st = S_INIT;
            m_last_wr = 1'b0;
        end else if (m_st == S_INIT) begin
            if (init_end) m_st = S_ARB;
        end else if (m_st == S_ARB) begin
            if (refresh_req) m_st = S_REF;
            else if (write_req || read_req) begin
                take_w = write_req && !(RR && read_req && m_last_wr);
                m_st = take_w ? S_WR : S_RD;
                m_last_wr = take_w;
            end
        end else if ((m_st == S_REF && refresh_end) || (m_st == S_WR && write_end) || (m_st == S_RD && read_end)) begin
            m_st = S_ARB;
        end
    endtask

    task automatic check_all();
        logic [3:0]  e_cmd;
        logic [1:0]  e_ba;
        logic [12:0] e_addr;
        e_cmd = 4'b0111;
        e_ba = 2'd0;
        e_addr = 13'd0;
        if (m_st == S_INIT) begin e_cmd = init_cmd; e_addr = init_addr; end
        if (m_st == S_REF) e_cmd = refresh_cmd;
        if (m_st == S_WR) begin e_cmd = write_cmd; e_ba = write_ba; e_addr = write_addr; end
        if (m_st == S_RD) begin e_cmd = read_cmd; e_ba = read_ba; e_addr = read_addr; end
        chk("state", 32'(arbit_state), 32'(m_st));
        chk("refresh_ack", 32'(refresh_ack), 32'(m_st == S_REF));
        chk("write_ack", 32'(write_ack), 32'(m_st == S_WR));
        chk("read_ack", 32'(read_ack), 32'(m_st == S_RD));
        chk("ack_onehot", 32'($countones({refresh_ack, write_ack, read_ack}) <= 1), 32'd1);
        chk("cmd", 32'(sdram_cmd), 32'(e_cmd));
        chk("ba", 32'(sdram_ba), 32'(e_ba));
        chk("addr", 32'(sdram_addr), 32'(e_addr));
    endtask

    task automatic cyc();
        @(posedge sysclk_100M);
        model_step();
        #2;
        check_all();
    endtask

    task automatic idle();
        {init_end, refresh_req, refresh_end, write_req, write_end, read_req, read_end} = '0;
    endtask

    task automatic reset_and_init();
        idle();
        init_cmd = 4'h2;
        init_addr = 13'h0400;
        rst = 1'b1;
        cyc();
        chk("rst_state", 32'(arbit_state), 32'd0);
        chk("rst_cmd", 32'(sdram_cmd), 32'h2);
        chk("rst_addr", 32'(sdram_addr), 32'h0400);
        chk("rst_ack", 32'({refresh_ack, write_ack, read_ack}), 32'd0);
        rst = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            cyc();
            chk("init_hold", 32'(arbit_state), 32'd0);
        end
        init_end = 1'b1;
        cyc();
        init_end = 1'b0;
        chk("init_to_arbit", 32'(arbit_state), 32'd1);
        chk("idle_nop", 32'(sdram_cmd), 32'h7);
        cyc();
        chk("idle_stay", 32'(arbit_state), 32'd1);
    endtask

    initial begin
        int exp_g, ack_cycles;
        idle();
        rst = 1'b1;
        {refresh_cmd, write_cmd, read_cmd} = '0;
        {write_ba, read_ba} = '0;
        {write_addr, read_addr} = '0;
        init_cmd = '0;
        init_addr = '0;
        reset_and_init();

        refresh_cmd = 4'b0001;
        refresh_req = 1'b1;
        cyc();
        chk("ref_grant", 32'(refresh_ack), 32'd1);
        chk("ref_cmd", 32'(sdram_cmd), 32'h1);
        refresh_req = 1'b0;
        ack_cycles = 1;
        for (int i = 0; i < 7; i++) begin
            cyc();
            ack_cycles += int'(refresh_ack);
        end
        refresh_end = 1'b1;
        cyc();
        refresh_end = 1'b0;
        chk("ref_ack_len", 32'(ack_cycles), 32'd8);
        chk("ref_release", 32'(refresh_ack), 32'd0);
        chk("ref_after_nop", 32'(sdram_cmd), 32'h7);

        write_req = 1'b1;
        refresh_req = 1'b1;
        cyc();
        chk("ref_beats_wr", 32'(arbit_state), 32'd2);
        refresh_req = 1'b0;
        refresh_end = 1'b1;
        cyc();
        refresh_end = 1'b0;
        chk("gap_after_ref", 32'(arbit_state), 32'd1);
        cyc();
        chk("wr_after_ref", 32'(arbit_state), 32'd3);

        write_addr = 13'h0ABC;
        write_ba = 2'd2;
        write_cmd = 4'b0100;
        refresh_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("no_preempt", 32'(arbit_state), 32'd3);
            chk("wr_addr", 32'(sdram_addr), 32'h0ABC);
            chk("wr_ba", 32'(sdram_ba), 32'd2);
        end
        write_req = 1'b0;
        write_end = 1'b1;
        cyc();
        write_end = 1'b0;
        chk("wr_release", 32'(arbit_state), 32'd1);
        cyc();
        chk("ref_after_wr", 32'(arbit_state), 32'd2);
        refresh_req = 1'b0;
        refresh_end = 1'b1;
        cyc();
        refresh_end = 1'b0;

        reset_and_init();
        write_req = 1'b1;
        read_req = 1'b1;
        for (int g = 0; g < 4; g++) begin
            exp_g = (RR && (g % 2 == 1)) ? S_RD : S_WR;
            cyc();
            chk("wr_rd_grant", 32'(arbit_state), 32'(exp_g));
            if (m_st == S_WR) write_end = 1'b1;
            else read_end = 1'b1;
            cyc();
            {write_end, read_end} = '0;
            chk("wr_rd_gap", 32'(arbit_state), 32'd1);
        end
        write_req = 1'b0;
        cyc();
        chk("rd_grant", 32'(read_ack), 32'd1);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_ack", 32'(read_ack), 32'd0);
        chk("async_rst_state", 32'(arbit_state), 32'd0);
        m_st = S_INIT;
        m_last_wr = 1'b0;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("no_grant_before_init", 32'(read_ack), 32'd0);
        end
        init_end = 1'b1;
        cyc();
        init_end = 1'b0;
        cyc();
        chk("rd_after_reinit", 32'(arbit_state), 32'd4);
        read_end = 1'b1;
        cyc();
        read_end = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 299) == 0);
            init_end    = ($urandom_range(0, 5) == 0);
            refresh_req = ($urandom_range(0, 7) == 0);
            write_req   = ($urandom_range(0, 2) == 0);
            read_req    = ($urandom_range(0, 2) == 0);
            refresh_end = ($urandom_range(0, 3) == 0);
            write_end   = ($urandom_range(0, 3) == 0);
            read_end    = ($urandom_range(0, 3) == 0);
            init_cmd    = 4'($urandom);
            refresh_cmd = 4'($urandom);
            write_cmd   = 4'($urandom);
            read_cmd    = 4'($urandom);
            init_addr   = 13'($urandom);
            write_addr  = 13'($urandom);
            read_addr   = 13'($urandom);
            write_ba    = 2'($urandom);
            read_ba     = 2'($urandom);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sdram_arbit.md
SDRAM_ARBIT -- requirements
Module: sdram_arbit

Interface
REQ-001 SHALL have port sysclk_100M  input  1  single system clock; all logic on its rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have ports init_end (in 1), init_cmd (in 4), init_addr (in 13): power-up init sequencer status, command and address.
REQ-004 SHALL have ports refresh_req (in 1), refresh_end (in 1), refresh_cmd (in 4), refresh_ack (out 1): auto-refresh requester handshake.
REQ-005 SHALL have ports write_req, write_end (in 1), write_cmd (in 4), write_ba (in 2), write_addr (in 13), write_ack (out 1): write requester.
REQ-006 SHALL have ports read_req, read_end (in 1), read_cmd (in 4), read_ba (in 2), read_addr (in 13), read_ack (out 1): read requester.
REQ-007 SHALL have ports sdram_cmd (out 4, {CS_n,RAS_n,CAS_n,WE_n}), sdram_ba (out 2), sdram_addr (out 13), arbit_state (out 3, state code for debug).

Function
REQ-008 SHALL implement a registered FSM: INIT=0, ARBIT=1, REFRESH=2, WRITE=3, READ=4.
REQ-009 INIT SHALL go to ARBIT on the first cycle init_end=1; otherwise stay in INIT.
REQ-010 In ARBIT, priority SHALL be refresh_req > write_req > read_req; the winner's state is entered on the next edge; with no request, stay in ARBIT.
REQ-011 REFRESH/WRITE/READ SHALL return to ARBIT on the cycle after the matching *_end=1; other *_end inputs are ignored.
REQ-012 Each ack SHALL be a pure decode of the registered state (refresh_ack = state==REFRESH, etc.); at most one ack high at any time.
REQ-013 An ack SHALL stay high continuously from grant until the cycle its *_end is sampled; deasserting req mid-grant SHALL NOT drop ack.
REQ-014 ARBIT SHALL last at least one cycle between two grants, guaranteeing at least one NOP between back-to-back operations, even if a req is high in the same cycle as *_end.
REQ-015 A request arriving during another grant SHALL wait; the running operation is never pre-empted, including by refresh_req.
REQ-016 The output mux SHALL be combinational from state: INIT -> init_cmd/init_addr, ba=0; REFRESH -> refresh_cmd, addr=0, ba=0; WRITE -> write_cmd/ba/addr; READ -> read_cmd/ba/addr; ARBIT -> NOP 4'b0111, addr=0, ba=0.
REQ-017 The write/read ba and addr inputs SHALL pass unmodified (no width change, no registering).
REQ-018 An undefined state encoding SHALL recover to INIT on the next edge with NOP output.

Reset
REQ-019 While rst=1, the state SHALL be INIT: acks=0, arbit_state=0, sdram_cmd=init_cmd, sdram_addr=init_addr, sdram_ba=0.
REQ-020 rst asserted mid-operation SHALL abort immediately (asynchronously) to INIT; the full init sequence is required again (init_end) before any grant.

Configuration
REQ-021 Macro ARBIT_RR_EN SHALL select write/read fairness.
REQ-022 ARBIT_RR_EN undefined: fixed priority per REQ-010.
REQ-023 ARBIT_RR_EN defined: a 1-bit last_grant register (reset 0 = read) SHALL give the tie to the opposite of the last write/read grant when both are pending; refresh stays highest priority; it updates only on a WRITE/READ grant.

Verification
REQ-024 Reset, init_end pulse at cycle 10 -> state INIT through cycle 10, ARBIT at 11, sdram_cmd=0111 while idle.
REQ-025 refresh_req held, refresh_cmd=0001 for one cycle, refresh_end 7 cycles after ack -> refresh_ack high exactly from grant to the cycle after end; cmd 0001 visible on sdram_cmd; ARBIT for 1 cycle afterwards.
REQ-026 write_req and refresh_req rise in the same ARBIT cycle -> REFRESH granted first; WRITE granted after refresh_end plus one ARBIT cycle.
REQ-027 refresh_req rises during WRITE (write_addr=13'h0ABC, ba=2) -> no pre-emption; sdram_addr=0ABC, ba=2 until write_end; then REFRESH.
REQ-028 write_req and read_req held high continuously for 4 grants -> undefined: W,W,W,W; with ARBIT_RR_EN: W,R,W,R.
REQ-029 rst pulsed during READ -> read_ack=0 asynchronously, state INIT; no grant until init_end is seen again.
